// File: rtl/turn_signal_pkg.sv
// Shared definitions for the turn-signal input conditioning block:
// debouncer state encoding, parameter defaults and the system clock rate.
package turn_signal_pkg;

  localparam int unsigned CLK_HZ              = 50_000_000;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 500_000;     // 10 ms at CLK_HZ
  localparam int unsigned TICK_DIV_DEF        = 12_500_000;  // 4 Hz step rate at CLK_HZ

  typedef enum logic [1:0] {
    ST_STABLE_LO = 2'd0,
    ST_ARM_HI    = 2'd1,
    ST_STABLE_HI = 2'd2,
    ST_ARM_LO    = 2'd3
  } deb_state_t;

endpackage

// File: rtl/signal_input_cond_if.sv
// Bundle between the lever inputs and the conditioning block; also carries
// the per-channel debouncer state for observation.
interface signal_input_cond_if;
  import turn_signal_pkg::*;

  // No valid/ready here: raw inputs and left/right are levels, the *_rise and
  // step_tick outputs are single-clock pulses that the consumer must not miss.
  logic       left_raw;
  logic       right_raw;
  logic       left;
  logic       right;
  logic       left_rise;
  logic       right_rise;
  logic       step_tick;
  deb_state_t left_state;
  deb_state_t right_state;

  modport master (
    output left_raw, right_raw,
    input  left, right, left_rise, right_rise, step_tick, left_state, right_state
  );

  modport slave (
    input  left_raw, right_raw,
    output left, right, left_rise, right_rise, step_tick, left_state, right_state
  );

endinterface

// File: rtl/debounce_channel.sv
// One lever channel: two-flop synchronizer, four-state debouncer, rise pulse.
// Define ACTIVE_LOW_BUTTONS_EN to invert the raw input ahead of the synchronizer.
module debounce_channel
  import turn_signal_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       raw_i,
  output logic       level_o,
  output logic       rise_o,
  output deb_state_t state_o
);

  localparam int unsigned     CW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0]   CNT_DONE = CW'(DEBOUNCE_CYCLES - 1);

  logic          raw_in;
  logic          sync1_q;
  logic          sync2_q;
  deb_state_t    state_q;
  logic [CW-1:0] count_q;
  logic          level_q;
  logic          level_prev_q;
  logic          rise_q;

`ifdef ACTIVE_LOW_BUTTONS_EN
  assign raw_in = ~raw_i;
`else
  assign raw_in = raw_i;
`endif

  // Entering ARM already counts one clock, so the ARM state completes once the
  // count has reached DEBOUNCE_CYCLES-1 on entry to the update (immediately for 1).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      state_q      <= ST_STABLE_LO;
      count_q      <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      rise_q       <= 1'b0;
    end else begin
      sync1_q      <= raw_in;
      sync2_q      <= sync1_q;
      level_prev_q <= level_q;
      rise_q       <= level_q & ~level_prev_q;
      case (state_q)
        ST_STABLE_LO: begin
          if (sync2_q) begin
            state_q <= ST_ARM_HI;
            count_q <= CW'(1);
          end
        end
        ST_ARM_HI: begin
          if (!sync2_q) begin
            state_q <= ST_STABLE_LO;
            count_q <= '0;
          end else if (count_q >= CNT_DONE) begin
            state_q <= ST_STABLE_HI;
            level_q <= 1'b1;
            count_q <= '0;
          end else begin
            count_q <= count_q + CW'(1);
          end
        end
        ST_STABLE_HI: begin
          if (!sync2_q) begin
            state_q <= ST_ARM_LO;
            count_q <= CW'(1);
          end
        end
        ST_ARM_LO: begin
          if (sync2_q) begin
            state_q <= ST_STABLE_HI;
            count_q <= '0;
          end else if (count_q >= CNT_DONE) begin
            state_q <= ST_STABLE_LO;
            level_q <= 1'b0;
            count_q <= '0;
          end else begin
            count_q <= count_q + CW'(1);
          end
        end
        default: begin
          state_q <= ST_STABLE_LO;
          count_q <= '0;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign state_o = state_q;

endmodule

// File: rtl/signal_input_cond.sv
// Turn-signal input conditioning: two debounced lever channels plus a free-running
// step_tick divider. Polarity option ACTIVE_LOW_BUTTONS_EN lives in debounce_channel.
module signal_input_cond
  import turn_signal_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned TICK_DIV        = TICK_DIV_DEF
) (
  input logic                clock,
  input logic                reset_n,
  signal_input_cond_if.slave bus
);

  localparam int unsigned   TW        = $clog2(TICK_DIV) + 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] tick_cnt_q;
  logic [TW-1:0] tick_cnt_d;
  logic          step_tick_q;

  always_comb begin
    tick_cnt_d = tick_cnt_q + TW'(1);
    if (tick_cnt_q == TICK_LAST) begin
      tick_cnt_d = '0;
    end
  end

  // step_tick is registered from the next count so it lines up with count==TICK_DIV-1.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_q  <= '0;
      step_tick_q <= 1'b0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      step_tick_q <= (tick_cnt_d == TICK_LAST);
    end
  end

  assign bus.step_tick = step_tick_q;

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_left (
    .clock   (clock),
    .reset_n (reset_n),
    .raw_i   (bus.left_raw),
    .level_o (bus.left),
    .rise_o  (bus.left_rise),
    .state_o (bus.left_state)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_right (
    .clock   (clock),
    .reset_n (reset_n),
    .raw_i   (bus.right_raw),
    .level_o (bus.right),
    .rise_o  (bus.right_rise),
    .state_o (bus.right_state)
  );

endmodule
